// File: rtl/i2c_slave.sv
// I2C target emulating an MPU-style register device: 7-bit address match, pointer write,
// burst write and burst read with auto-increment against an external 256x8 register file.
module i2c_slave #(
    parameter logic [6:0] DEVICE_ADDR = 7'b1101000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    input  logic       SDA_IN,
    output logic       SDA_OUT,
    output logic       SDA_DIR,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WEN,
    input  logic [7:0] REG_RDATA,
    output logic       REG_REN,
    output logic       BUSY,
    output logic       NACK_SEEN
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       wen_q, wen_d;
    logic       ren_q, ren_d;
    logic       dir_q, dir_d;
    logic       busy_q, busy_d;
    logic       nack_q, nack_d;
    logic       rw_q, rw_d;

    // Synchronisers reset to the idle-bus level so reset release never fakes an edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_IN};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            nack_q  <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            nack_q  <= nack_d;
            rw_q    <= rw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
        dir_d   = dir_q;
        busy_d  = busy_q;
        nack_d  = nack_q;
        rw_d    = rw_q;

        // The pointer advances the cycle after each write strobe
        if (wen_q)
            addr_d = addr_q + 8'd1;

        if (start_det) begin
            state_d = ADDR;
            cnt_d   = '0;
            dir_d   = 1'b0;
            nack_d  = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            dir_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WRITE: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        case (state_q)
                            ADDR: begin
                                if (shift_q[7:1] == DEVICE_ADDR) begin
                                    state_d = ADDR_ACK;
                                    dir_d   = 1'b1;
                                    busy_d  = 1'b1;
                                    rw_d    = shift_q[0];
                                end else begin
                                    state_d = IGNORE;
                                end
                            end
                            PTR: begin
                                addr_d  = shift_q;
                                state_d = PTR_ACK;
                                dir_d   = 1'b1;
                            end
                            default: begin
                                wdata_d = shift_q;
                                state_d = WRITE_ACK;
                                dir_d   = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            shift_d = REG_RDATA;
                            ren_d   = 1'b1;
                            dir_d   = ~REG_RDATA[7];
                            state_d = READ;
                        end else begin
                            dir_d   = 1'b0;
                            state_d = PTR;
                        end
                    end
                end
                PTR_ACK: begin
                    if (scl_fall) begin
                        dir_d   = 1'b0;
                        state_d = WRITE;
                    end
                end
                WRITE_ACK: begin
                    if (scl_rise)
                        wen_d = 1'b1;
                    if (scl_fall) begin
                        dir_d   = 1'b0;
                        state_d = WRITE;
                    end
                end
                // Drive only zeros; a one bit is sent by releasing the line
                READ: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        dir_d   = 1'b0;
                        addr_d  = addr_q + 8'd1;
                        cnt_d   = '0;
                        state_d = READ_ACK;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        dir_d   = ~shift_q[6];
                    end
                end
                READ_ACK: begin
                    if (scl_rise && sda_s) begin
                        nack_d  = 1'b1;
                        state_d = WAIT_STOP;
                    end else if (scl_fall) begin
                        shift_d = REG_RDATA;
                        ren_d   = 1'b1;
                        dir_d   = ~REG_RDATA[7];
                        state_d = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SDA_DIR   = dir_q;
    assign SDA_OUT   = ~dir_q;
    assign REG_ADDR  = addr_q;
    assign REG_WDATA = wdata_q;
    assign REG_WEN   = wen_q;
    assign REG_REN   = ren_q;
    assign BUSY      = busy_q;
    assign NACK_SEEN = nack_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level bus master drives directed transactions while a
// monitor checks register strobes against queued expectations.
module tb_i2c_slave;

    localparam int Q = 10;

    typedef enum {BUS_START, BUS_STOP, BUS_WRITE, BUS_READ_ACK, BUS_READ_NACK} bus_op_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       SDA_OUT, SDA_DIR, REG_WEN, REG_REN, BUSY, NACK_SEEN;
    logic [7:0] REG_ADDR, REG_WDATA, REG_RDATA;

    int          checks = 0;
    int          errors = 0;
    int          dir_cnt = 0;
    int          busy_cnt = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    assign sda_bus   = sda_m & ~(SDA_DIR & ~SDA_OUT);
    assign REG_RDATA = REG_ADDR ^ 8'hA5;

    always #5 CLK = ~CLK;

    i2c_slave #(.DEVICE_ADDR(7'h68), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .SCL(scl_m), .SDA_IN(sda_bus),
        .SDA_OUT(SDA_OUT), .SDA_DIR(SDA_DIR),
        .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_WEN(REG_WEN),
        .REG_RDATA(REG_RDATA), .REG_REN(REG_REN),
        .BUSY(BUSY), .NACK_SEEN(NACK_SEEN)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clockBit(input logic bit_out, output logic bit_in);
        sda_m = bit_out;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        bit_in = sda_bus;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic applyStimulus(input bus_op_t op, input logic [7:0] data, input logic expect_ack);
        logic       b;
        logic [7:0] rx;
        case (op)
            BUS_START: begin
                sda_m = 1'b1; tick(Q);
                scl_m = 1'b1; tick(Q);
                sda_m = 1'b0; tick(Q);
                scl_m = 1'b0; tick(Q);
            end
            BUS_STOP: begin
                sda_m = 1'b0; tick(Q);
                scl_m = 1'b1; tick(Q);
                sda_m = 1'b1; tick(Q);
            end
            BUS_WRITE: begin
                for (int i = 7; i >= 0; i--)
                    clockBit(data[i], b);
                clockBit(1'b1, b);
                checkOutput($sformatf("ack_level_%02h", data), int'(b), expect_ack ? 0 : 1);
            end
            default: begin
                rx = '0;
                for (int i = 0; i < 8; i++) begin
                    clockBit(1'b1, b);
                    rx = {rx[6:0], b};
                end
                clockBit(op == BUS_READ_NACK, b);
                checkOutput("read_byte", int'(rx), int'(data));
            end
        endcase
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge CLK) begin
        if (SDA_DIR)
            dir_cnt <= dir_cnt + 1;
        if (BUSY)
            busy_cnt <= busy_cnt + 1;
        if (REG_WEN || REG_REN)
            checkOutput("strobe_exclusive", int'(REG_WEN & REG_REN), 0);
        if (REG_WEN) begin
            checkOutput("wen_pending", int'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0)
                checkOutput("wen_addr_data", int'({REG_ADDR, REG_WDATA}), int'(exp_wr.pop_front()));
        end
        if (REG_REN) begin
            checkOutput("ren_pending", int'(exp_rd.size() > 0), 1);
            if (exp_rd.size() > 0)
                checkOutput("ren_addr", int'(REG_ADDR), int'(exp_rd.pop_front()));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired before end of sequence");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         d0, b0;
        logic       b;
        logic [7:0] a;

        tick(5);
        checkOutput("rst_sda_dir", int'(SDA_DIR), 0);
        checkOutput("rst_sda_out", int'(SDA_OUT), 1);
        checkOutput("rst_reg_addr", int'(REG_ADDR), 0);
        checkOutput("rst_reg_wdata", int'(REG_WDATA), 0);
        checkOutput("rst_strobes", int'({REG_WEN, REG_REN}), 0);
        checkOutput("rst_busy_nack", int'({BUSY, NACK_SEEN}), 0);
        RST = 1'b1;
        tick(5);

        $display("[TB] single register write");
        exp_wr.push_back(16'h6B00);
        applyStimulus(BUS_START, 8'h00, 1'b0);
        applyStimulus(BUS_WRITE, 8'hD0, 1'b1);
        checkOutput("busy_after_addr", int'(BUSY), 1);
        applyStimulus(BUS_WRITE, 8'h6B, 1'b1);
        applyStimulus(BUS_WRITE, 8'h00, 1'b1);
        applyStimulus(BUS_STOP, 8'h00, 1'b0);
        tick(10);
        checkOutput("write_final_addr", int'(REG_ADDR), 8'h6C);
        checkOutput("busy_after_stop", int'(BUSY), 0);

        $display("[TB] burst read of 14 bytes from 0x3B");
        applyStimulus(BUS_START, 8'h00, 1'b0);
        applyStimulus(BUS_WRITE, 8'hD0, 1'b1);
        applyStimulus(BUS_WRITE, 8'h3B, 1'b1);
        applyStimulus(BUS_START, 8'h00, 1'b0);
        for (int i = 0; i < 14; i++) begin
            a = 8'h3B + 8'(i);
            exp_rd.push_back(a);
        end
        applyStimulus(BUS_WRITE, 8'hD1, 1'b1);
        for (int i = 0; i < 14; i++) begin
            a = 8'h3B + 8'(i);
            applyStimulus(i == 13 ? BUS_READ_NACK : BUS_READ_ACK, a ^ 8'hA5, 1'b0);
        end
        applyStimulus(BUS_STOP, 8'h00, 1'b0);
        tick(10);
        checkOutput("read_nack_seen", int'(NACK_SEEN), 1);
        checkOutput("read_final_addr", int'(REG_ADDR), 8'h49);
        checkOutput("read_ren_count", exp_rd.size(), 0);
        checkOutput("read_busy_after_stop", int'(BUSY), 0);

        $display("[TB] address mismatch");
        d0 = dir_cnt;
        b0 = busy_cnt;
        applyStimulus(BUS_START, 8'h00, 1'b0);
        applyStimulus(BUS_WRITE, 8'hA0, 1'b0);
        applyStimulus(BUS_WRITE, 8'h55, 1'b0);
        applyStimulus(BUS_STOP, 8'h00, 1'b0);
        tick(10);
        checkOutput("mismatch_sda_driven_cycles", dir_cnt - d0, 0);
        checkOutput("mismatch_busy_cycles", busy_cnt - b0, 0);
        checkOutput("mismatch_nack_cleared", int'(NACK_SEEN), 0);
        checkOutput("mismatch_addr_kept", int'(REG_ADDR), 8'h49);

        $display("[TB] pointer wrap on write");
        exp_wr.push_back(16'hFF11);
        exp_wr.push_back(16'h0022);
        applyStimulus(BUS_START, 8'h00, 1'b0);
        applyStimulus(BUS_WRITE, 8'hD0, 1'b1);
        applyStimulus(BUS_WRITE, 8'hFF, 1'b1);
        applyStimulus(BUS_WRITE, 8'h11, 1'b1);
        applyStimulus(BUS_WRITE, 8'h22, 1'b1);
        applyStimulus(BUS_STOP, 8'h00, 1'b0);
        tick(10);
        checkOutput("wrap_final_addr", int'(REG_ADDR), 8'h01);

        $display("[TB] reset while driving a read bit");
        applyStimulus(BUS_START, 8'h00, 1'b0);
        applyStimulus(BUS_WRITE, 8'hD0, 1'b1);
        applyStimulus(BUS_WRITE, 8'h10, 1'b1);
        applyStimulus(BUS_START, 8'h00, 1'b0);
        exp_rd.push_back(8'h10);
        applyStimulus(BUS_WRITE, 8'hD1, 1'b1);
        clockBit(1'b1, b);
        checkOutput("reset_read_msb", int'(b), 1);
        checkOutput("reset_driving_zero", int'(SDA_DIR), 1);
        RST = 1'b0;
        #1;
        checkOutput("reset_async_release", int'(SDA_DIR), 0);
        checkOutput("reset_sda_out", int'(SDA_OUT), 1);
        checkOutput("reset_addr", int'(REG_ADDR), 0);
        checkOutput("reset_busy", int'(BUSY), 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(5);
        RST = 1'b1;
        tick(5);
        exp_wr.push_back(16'h2077);
        applyStimulus(BUS_START, 8'h00, 1'b0);
        applyStimulus(BUS_WRITE, 8'hD0, 1'b1);
        applyStimulus(BUS_WRITE, 8'h20, 1'b1);
        applyStimulus(BUS_WRITE, 8'h77, 1'b1);
        applyStimulus(BUS_STOP, 8'h00, 1'b0);
        tick(10);
        checkOutput("recover_final_addr", int'(REG_ADDR), 8'h21);

        checkOutput("wen_queue_drained", exp_wr.size(), 0);
        checkOutput("ren_queue_drained", exp_rd.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
